// File: rtl/hazard_controller_if.sv
// Bundle of pipeline hazard inputs and stall/flush controls between the
// pipeline datapath (master) and the hazard controller (slave).
interface hazard_controller_if #(
  parameter int REGW = 5,
  parameter int CNTW = 16
);
  logic            ihit;
  logic            dhit;
  logic            idex_memread;
  logic [REGW-1:0] idex_rd;
  logic [REGW-1:0] ifid_rs;
  logic [REGW-1:0] ifid_rt;
  logic            ifid_uses_rt;
  logic            exmem_dren;
  logic            exmem_dwen;
  logic            branch_taken;
  logic            memwb_halt;

  logic            ifidStall;
  logic            idexStall;
  logic            allStall;
  logic            ifidFlush;
  logic            idexFlush;
  logic            exmemFlush;
  logic            pc_en;
  logic            halted;
  logic            wait_err;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output ihit, dhit, idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           exmem_dren, exmem_dwen, branch_taken, memwb_halt,
    input  ifidStall, idexStall, allStall, ifidFlush, idexFlush, exmemFlush,
           pc_en, halted, wait_err, stall_cycles
  );

  modport slave (
    input  ihit, dhit, idex_memread, idex_rd, ifid_rs, ifid_rt, ifid_uses_rt,
           exmem_dren, exmem_dwen, branch_taken, memwb_halt,
    output ifidStall, idexStall, allStall, ifidFlush, idexFlush, exmemFlush,
           pc_en, halted, wait_err, stall_cycles
  );
endinterface

// File: rtl/hazard_controller.sv
// Five-stage pipeline hazard controller: load-use, branch flush, data-memory
// freeze with watchdog, halt, and a saturating stall-cycle counter.
module hazard_controller #(
  parameter int REGW    = 5,
  parameter int CNTW    = 16,
  parameter int MAXWAIT = 255
) (
  input  logic          CLK,
  input  logic          RST,
  hazard_controller_if.slave hzd
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  state_t          stateReg, stateNext;
  logic [15:0]     waitCntReg, waitCntNext;
  logic            waitErrReg, waitErrNext;
  logic [CNTW-1:0] stallCntReg;

  logic memReq, memPending, loadUse;
  logic ifidStallC, idexStallC, allStallC, ifidFlushC, idexFlushC, pcEnC, haltedC;

  assign memReq     = hzd.exmem_dren | hzd.exmem_dwen;
  assign memPending = memReq & ~hzd.dhit;
  assign loadUse    = hzd.idex_memread & (hzd.idex_rd != REGW'(0)) &
                      ((hzd.idex_rd == hzd.ifid_rs) |
                       (hzd.ifid_uses_rt & (hzd.idex_rd == hzd.ifid_rt)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      stateReg    <= RUN;
      waitCntReg  <= '0;
      waitErrReg  <= 1'b0;
      stallCntReg <= '0;
    end else begin
      stateReg   <= stateNext;
      waitCntReg <= waitCntNext;
      waitErrReg <= waitErrNext;
      if ((allStallC | idexStallC) && (stallCntReg != {CNTW{1'b1}}))
        stallCntReg <= stallCntReg + CNTW'(1);
    end
  end

  always_comb begin
    ifidStallC  = 1'b0;
    idexStallC  = 1'b0;
    allStallC   = 1'b0;
    ifidFlushC  = 1'b0;
    idexFlushC  = 1'b0;
    pcEnC       = 1'b0;
    haltedC     = 1'b0;
    stateNext   = stateReg;
    waitCntNext = waitCntReg;
    waitErrNext = waitErrReg;

    case (stateReg)
      RUN, MEMWAIT: begin
        if ((stateReg == RUN) ? memPending : ~hzd.dhit) begin
          // Frozen on data memory; a held branch waits for the release cycle.
          allStallC = 1'b1;
          stateNext = MEMWAIT;
          if (stateReg == RUN)
            waitCntNext = 16'd1;
          else if (waitCntReg != 16'hFFFF)
            waitCntNext = waitCntReg + 16'd1;
        end else begin
          if (hzd.branch_taken) begin
            ifidFlushC = 1'b1;
            idexFlushC = 1'b1;
            pcEnC      = hzd.ihit;
          end else if (loadUse) begin
            idexStallC = 1'b1;
          end else begin
            pcEnC = hzd.ihit;
          end
          waitCntNext = '0;
          stateNext   = hzd.memwb_halt ? HALTED : RUN;
        end
      end
      HALTED: begin
        allStallC = 1'b1;
        haltedC   = 1'b1;
      end
      default: stateNext = RUN;
    endcase

    if ((stateNext == MEMWAIT) && (waitCntNext >= 16'(MAXWAIT)))
      waitErrNext = 1'b1;

    // Controls read as idle while reset is held.
    if (RST) begin
      ifidStallC = 1'b0;
      idexStallC = 1'b0;
      allStallC  = 1'b0;
      ifidFlushC = 1'b0;
      idexFlushC = 1'b0;
      pcEnC      = 1'b0;
      haltedC    = 1'b0;
    end
  end

  assign hzd.ifidStall    = ifidStallC;
  assign hzd.idexStall    = idexStallC;
  assign hzd.allStall     = allStallC;
  assign hzd.ifidFlush    = ifidFlushC;
  assign hzd.idexFlush    = idexFlushC;
  assign hzd.exmemFlush   = 1'b0;
  assign hzd.pc_en        = pcEnC;
  assign hzd.halted       = haltedC;
  assign hzd.wait_err     = waitErrReg & ~RST;
  assign hzd.stall_cycles = RST ? '0 : stallCntReg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use, branch, memory freeze,
// watchdog, halt and stall-counter saturation.
module tb_hazard_controller;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  hazard_controller_if #(.REGW(5), .CNTW(16)) hif ();

  hazard_controller #(.REGW(5), .CNTW(16), .MAXWAIT(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .hzd (hif.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle();
    hif.ihit         = 1'b1;
    hif.dhit         = 1'b0;
    hif.idex_memread = 1'b0;
    hif.idex_rd      = '0;
    hif.ifid_rs      = '0;
    hif.ifid_rt      = '0;
    hif.ifid_uses_rt = 1'b0;
    hif.exmem_dren   = 1'b0;
    hif.exmem_dwen   = 1'b0;
    hif.branch_taken = 1'b0;
    hif.memwb_halt   = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    idle();
    cyc();
    cyc();
    mid();
    check("rst_allStall", hif.allStall, 0);
    check("rst_idexStall", hif.idexStall, 0);
    check("rst_pc_en", hif.pc_en, 0);
    check("rst_halted", hif.halted, 0);
    check("rst_wait_err", hif.wait_err, 0);
    check("rst_stall_cycles", hif.stall_cycles, 0);
    cyc();
    RST = 1'b0;

    mid();
    check("idle_pc_en", hif.pc_en, 1);
    check("idle_allStall", hif.allStall, 0);
    cyc();
    hif.ihit = 1'b0;
    mid();
    check("noihit_pc_en", hif.pc_en, 0);
    check("noihit_ifidStall", hif.ifidStall, 0);
    check("noihit_allStall", hif.allStall, 0);
    cyc();

    // load-use on rs, then the load moves on
    hif.ihit = 1'b1;
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd3; hif.ifid_rs = 5'd3;
    mid();
    check("lu_rs_idexStall", hif.idexStall, 1);
    check("lu_rs_pc_en", hif.pc_en, 0);
    check("lu_rs_ifidFlush", hif.ifidFlush, 0);
    cyc();
    hif.idex_memread = 1'b0; hif.idex_rd = 5'd0;
    mid();
    check("lu_after_idexStall", hif.idexStall, 0);
    check("lu_after_pc_en", hif.pc_en, 1);
    check("lu_after_count", hif.stall_cycles, 1);
    cyc();
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd0; hif.ifid_rs = 5'd0;
    mid();
    check("lu_r0_idexStall", hif.idexStall, 0);
    check("lu_r0_pc_en", hif.pc_en, 1);
    cyc();
    hif.idex_rd = 5'd5; hif.ifid_rs = 5'd2; hif.ifid_rt = 5'd5; hif.ifid_uses_rt = 1'b1;
    mid();
    check("lu_rt_idexStall", hif.idexStall, 1);
    cyc();
    hif.ifid_uses_rt = 1'b0;
    mid();
    check("lu_rt_unused_idexStall", hif.idexStall, 0);
    check("lu_count", hif.stall_cycles, 2);
    cyc();

    // taken branch
    idle();
    hif.branch_taken = 1'b1;
    mid();
    check("br_ifidFlush", hif.ifidFlush, 1);
    check("br_idexFlush", hif.idexFlush, 1);
    check("br_pc_en", hif.pc_en, 1);
    check("br_exmemFlush", hif.exmemFlush, 0);
    cyc();
    hif.idex_memread = 1'b1; hif.idex_rd = 5'd3; hif.ifid_rs = 5'd3;
    mid();
    check("br_lu_idexStall", hif.idexStall, 0);
    check("br_lu_idexFlush", hif.idexFlush, 1);
    cyc();
    idle();
    hif.branch_taken = 1'b1; hif.ihit = 1'b0;
    mid();
    check("br_noihit_pc_en", hif.pc_en, 0);
    check("br_noihit_ifidFlush", hif.ifidFlush, 1);
    cyc();
    idle();
    mid();
    check("br_done_ifidFlush", hif.ifidFlush, 0);
    check("br_count", hif.stall_cycles, 2);
    cyc();

    // data-memory freeze for four cycles
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    hif.exmem_dren = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("mw_allStall", hif.allStall, 1);
      check("mw_pc_en", hif.pc_en, 0);
      cyc();
    end
    hif.dhit = 1'b1;
    mid();
    check("mw_rel_allStall", hif.allStall, 0);
    check("mw_rel_pc_en", hif.pc_en, 1);
    cyc();
    idle();
    mid();
    check("mw_run_allStall", hif.allStall, 0);
    check("mw_count", hif.stall_cycles, 4);
    cyc();

    // branch held through a three-cycle freeze
    hif.exmem_dwen = 1'b1; hif.branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("mwbr_ifidFlush", hif.ifidFlush, 0);
      check("mwbr_idexFlush", hif.idexFlush, 0);
      check("mwbr_allStall", hif.allStall, 1);
      cyc();
    end
    hif.dhit = 1'b1;
    mid();
    check("mwbr_rel_ifidFlush", hif.ifidFlush, 1);
    check("mwbr_rel_idexFlush", hif.idexFlush, 1);
    check("mwbr_rel_pc_en", hif.pc_en, 1);
    cyc();
    idle();
    mid();
    check("mwbr_done_ifidFlush", hif.ifidFlush, 0);
    check("mwbr_count", hif.stall_cycles, 7);
    cyc();

    // watchdog with MAXWAIT = 8
    hif.exmem_dren = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      mid();
      check("wd_pre_wait_err", hif.wait_err, 0);
      check("wd_allStall", hif.allStall, 1);
      cyc();
    end
    for (int i = 0; i < 4; i++) begin
      mid();
      check("wd_wait_err", hif.wait_err, 1);
      cyc();
    end
    hif.dhit = 1'b1;
    mid();
    check("wd_rel_allStall", hif.allStall, 0);
    cyc();
    idle();
    mid();
    check("wd_sticky", hif.wait_err, 1);
    cyc();

    // reset while frozen returns to RUN
    hif.exmem_dren = 1'b1;
    cyc();
    idle();
    mid();
    check("mwrst_frozen_allStall", hif.allStall, 1);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    mid();
    check("mwrst_allStall", hif.allStall, 0);
    check("mwrst_pc_en", hif.pc_en, 1);
    check("mwrst_wait_err", hif.wait_err, 0);
    check("mwrst_count", hif.stall_cycles, 0);
    cyc();

    // dhit and halt together while frozen
    hif.exmem_dren = 1'b1;
    cyc();
    hif.dhit = 1'b1; hif.memwb_halt = 1'b1;
    mid();
    check("mwh_rel_allStall", hif.allStall, 0);
    check("mwh_rel_halted", hif.halted, 0);
    cyc();
    idle();
    mid();
    check("mwh_halted", hif.halted, 1);
    check("mwh_allStall", hif.allStall, 1);
    check("mwh_pc_en", hif.pc_en, 0);
    cyc();

    // halt from RUN, then counter saturation
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    hif.memwb_halt = 1'b1;
    mid();
    check("h_entry_halted", hif.halted, 0);
    check("h_entry_pc_en", hif.pc_en, 1);
    cyc();
    hif.memwb_halt = 1'b0;
    mid();
    check("h_halted", hif.halted, 1);
    check("h_count0", hif.stall_cycles, 0);
    repeat (10) cyc();
    mid();
    check("h_count10", hif.stall_cycles, 10);
    repeat (65530) cyc();
    mid();
    check("h_sat", hif.stall_cycles, 65535);
    check("h_still_halted", hif.halted, 1);
    cyc();
    mid();
    check("h_sat_hold", hif.stall_cycles, 65535);
    check("h_allStall", hif.allStall, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
